// File: rtl/sequence_detector_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
// Holds the default configuration, the overlap-mode encoding, the legal
// range of the pattern length and small helpers used by the detector files.
package sequence_detector_pkg;

    // Default build-time sizes
    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;

    // Hard limits on the pattern register width
    localparam int MIN_MAX_LEN = 2;
    localparam int TOP_MAX_LEN = 32;

    // Configuration loaded on reset: the classic 1011 detector, overlapping
    localparam logic [7:0] DEF_PATTERN = 8'b0000_1011;
    localparam int         DEF_LEN     = 4;
    localparam bit         DEF_OVERLAP = 1'b1;

    // Overlap mode encoding carried by cfg_overlap
    localparam logic OVERLAP_ON  = 1'b1;
    localparam logic OVERLAP_OFF = 1'b0;

    // Width needed to hold a length value 0..max_len
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // True when the build-time pattern width is supported
    function automatic bit max_len_ok(input int max_len);
        return (max_len >= MIN_MAX_LEN) && (max_len <= TOP_MAX_LEN);
    endfunction

    // True when a programmed length is usable with a given pattern width
    function automatic logic len_in_range(input int len, input int max_len);
        return (len >= 1) && (len <= max_len);
    endfunction

endpackage

// File: rtl/sequence_detector_param_seq_match_core.sv
// seq_match_core: history shift register, saturating fill counter and
// length-masked pattern compare.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   clear         - empty the history (reconfiguration)
//   shift_en      - accept bit_in this cycle
//   bit_in        - serial data bit
//   pattern, len  - active pattern (LSB = last bit) and its length
//   overlap       - OVERLAP_ON keeps history after a match
//   match_next    - combinational: the bit accepted this cycle completes a match
module seq_match_core
    import sequence_detector_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               bit_in,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               match_next
);

    logic [MAX_LEN-1:0] history_r;
    logic [MAX_LEN-1:0] history_next_s;
    logic [LEN_W-1:0]   fill_r;
    logic [LEN_W-1:0]   fill_next_s;
    logic [MAX_LEN-1:0] mask_s;
    logic               match_s;

    // Next history/fill assuming the current bit is accepted
    always_comb begin
        history_next_s = history_r;
        fill_next_s    = fill_r;
        if (shift_en) begin
            history_next_s = {history_r[MAX_LEN-2:0], bit_in};
            if (fill_r == LEN_W'(MAX_LEN)) begin
                fill_next_s = fill_r;
            end else begin
                fill_next_s = fill_r + LEN_W'(1);
            end
        end else begin
            history_next_s = history_r;
            fill_next_s    = fill_r;
        end
    end

    // Mask selecting the low len bits; pattern bits above len-1 never count
    always_comb begin
        mask_s = {MAX_LEN{1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            mask_s[i] = (i < int'(len));
        end
    end

    // Match decision on the updated history, only for an accepted bit
    always_comb begin
        match_s = 1'b0;
        if (shift_en && (fill_next_s >= len)) begin
            match_s = (((history_next_s ^ pattern) & mask_s) == {MAX_LEN{1'b0}});
        end else begin
            match_s = 1'b0;
        end
    end

    assign match_next = match_s;

    // History and fill state; non-overlap mode restarts the fill after a match
    always_ff @(posedge clock) begin
        if (reset) begin
            history_r <= {MAX_LEN{1'b0}};
            fill_r    <= {LEN_W{1'b0}};
        end else if (clear) begin
            history_r <= {MAX_LEN{1'b0}};
            fill_r    <= {LEN_W{1'b0}};
        end else if (shift_en) begin
            history_r <= history_next_s;
            if (match_s && (overlap == OVERLAP_OFF)) begin
                fill_r <= {LEN_W{1'b0}};
            end else begin
                fill_r <= fill_next_s;
            end
        end else begin
            history_r <= history_r;
            fill_r    <= fill_r;
        end
    end

endmodule

// File: rtl/sequence_detector_param.sv
// sequence_detector_param: runtime-programmable serial pattern detector.
// Ports:
//   clock, reset    - rising-edge clock, synchronous active-high reset
//   cfg_load        - load cfg_pattern/cfg_len/cfg_overlap (illegal len rejected)
//   cfg_pattern     - pattern, [len-1] received first, [0] received last
//   cfg_len         - pattern length 1..MAX_LEN
//   cfg_overlap     - 1 overlapping matches, 0 non-overlapping
//   count_clr       - clear match_count (wins over a simultaneous match)
//   sequence_valid  - sequence_in carries a bit this cycle
//   sequence_in     - serial data bit
//   detector_out    - registered one-cycle match pulse
//   match_count     - saturating match counter
//   count_sat       - match_count is all-ones
//   cfg_err         - one-cycle pulse when a cfg_load with illegal cfg_len is rejected
module sequence_detector_param
    import sequence_detector_pkg::*;
#(
    parameter int                 MAX_LEN         = DEF_MAX_LEN,
    parameter int                 LEN_W           = $clog2(MAX_LEN + 1),
    parameter int                 CNT_W           = DEF_CNT_W,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(DEF_PATTERN),
    parameter int                 DEFAULT_LEN     = DEF_LEN,
    parameter bit                 DEFAULT_OVERLAP = DEF_OVERLAP
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clr,
    input  logic               sequence_valid,
    input  logic               sequence_in,
    output logic               detector_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat,
    output logic               cfg_err
);

    // Build-time sanity checks on the parameter set
    if (!max_len_ok(MAX_LEN)) begin : g_bad_max_len
        $error("sequence_detector_param: MAX_LEN must be within 2..32");
    end
    if (LEN_W != len_width(MAX_LEN)) begin : g_bad_len_w
        $error("sequence_detector_param: LEN_W must not be overridden");
    end
    if (!len_in_range(DEFAULT_LEN, MAX_LEN)) begin : g_bad_default_len
        $error("sequence_detector_param: DEFAULT_LEN must be within 1..MAX_LEN");
    end

    logic [MAX_LEN-1:0] pattern_r;
    logic [LEN_W-1:0]   len_r;
    logic               overlap_r;
    logic               detector_out_r;
    logic [CNT_W-1:0]   count_r;
    logic               count_sat_r;
    logic               cfg_err_r;

    logic               len_legal_s;
    logic               cfg_apply_s;
    logic               cfg_reject_s;
    logic               accept_s;
    logic               match_s;
    logic [CNT_W-1:0]   count_next_s;

    // Classify a configuration request; any load cycle drops the data bit
    always_comb begin
        len_legal_s  = len_in_range(int'(cfg_len), MAX_LEN);
        cfg_apply_s  = 1'b0;
        cfg_reject_s = 1'b0;
        accept_s     = 1'b0;
        if (cfg_load) begin
            cfg_apply_s  = len_legal_s;
            cfg_reject_s = ~len_legal_s;
            accept_s     = 1'b0;
        end else begin
            cfg_apply_s  = 1'b0;
            cfg_reject_s = 1'b0;
            accept_s     = sequence_valid;
        end
    end

    seq_match_core #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_core (
        .clock      (clock),
        .reset      (reset),
        .clear      (cfg_apply_s),
        .shift_en   (accept_s),
        .bit_in     (sequence_in),
        .pattern    (pattern_r),
        .len        (len_r),
        .overlap    (overlap_r),
        .match_next (match_s)
    );

    // Counter next value: clear wins, then saturating increment on a match
    always_comb begin
        count_next_s = count_r;
        if (count_clr) begin
            count_next_s = {CNT_W{1'b0}};
        end else if (match_s && (count_r != {CNT_W{1'b1}})) begin
            count_next_s = count_r + CNT_W'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Active configuration registers, reloaded only by a legal cfg_load
    always_ff @(posedge clock) begin
        if (reset) begin
            pattern_r <= DEFAULT_PATTERN;
            len_r     <= LEN_W'(DEFAULT_LEN);
            overlap_r <= DEFAULT_OVERLAP;
        end else if (cfg_apply_s) begin
            pattern_r <= cfg_pattern;
            len_r     <= cfg_len;
            overlap_r <= cfg_overlap;
        end else begin
            pattern_r <= pattern_r;
            len_r     <= len_r;
            overlap_r <= overlap_r;
        end
    end

    // Registered outputs: match pulse, counter with its saturation flag, error pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            detector_out_r <= 1'b0;
            count_r        <= {CNT_W{1'b0}};
            count_sat_r    <= 1'b0;
            cfg_err_r      <= 1'b0;
        end else begin
            detector_out_r <= match_s;
            count_r        <= count_next_s;
            count_sat_r    <= (count_next_s == {CNT_W{1'b1}});
            cfg_err_r      <= cfg_reject_s;
        end
    end

    assign detector_out = detector_out_r;
    assign match_count  = count_r;
    assign count_sat    = count_sat_r;
    assign cfg_err      = cfg_err_r;

endmodule

// File: tb/tb_sequence_detector_param.sv
// Directed bench for sequence_detector_param. Instance u_dut uses the default
// sizes; u_sat uses a 2-bit counter for the saturation scenario. Both share
// the same stimulus. Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, after the edge has updated them.
module tb_sequence_detector_param;

    logic       clock;
    logic       reset;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       count_clr;
    logic       sequence_valid;
    logic       sequence_in;

    logic       a_det;
    logic [7:0] a_cnt;
    logic       a_sat;
    logic       a_err;
    logic       b_det;
    logic [1:0] b_cnt;
    logic       b_sat;
    logic       b_err;

    int n_cmp;
    int n_fail;

    sequence_detector_param u_dut (
        .clock          (clock),
        .reset          (reset),
        .cfg_load       (cfg_load),
        .cfg_pattern    (cfg_pattern),
        .cfg_len        (cfg_len),
        .cfg_overlap    (cfg_overlap),
        .count_clr      (count_clr),
        .sequence_valid (sequence_valid),
        .sequence_in    (sequence_in),
        .detector_out   (a_det),
        .match_count    (a_cnt),
        .count_sat      (a_sat),
        .cfg_err        (a_err)
    );

    sequence_detector_param #(.CNT_W(2)) u_sat (
        .clock          (clock),
        .reset          (reset),
        .cfg_load       (cfg_load),
        .cfg_pattern    (cfg_pattern),
        .cfg_len        (cfg_len),
        .cfg_overlap    (cfg_overlap),
        .count_clr      (count_clr),
        .sequence_valid (sequence_valid),
        .sequence_in    (sequence_in),
        .detector_out   (b_det),
        .match_count    (b_cnt),
        .count_sat      (b_sat),
        .cfg_err        (b_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_load       = 1'b0;
        count_clr      = 1'b0;
        sequence_valid = 1'b0;
        sequence_in    = 1'b0;
    endtask

    task automatic test_reset();
        // reset must override an illegal load and a valid bit
        reset = 1'b1; cfg_load = 1'b1; cfg_len = 4'd0; sequence_valid = 1'b1; sequence_in = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        idle_inputs();
        n_cmp++; if (a_det !== 1'b0) begin n_fail++; $display("FAIL reset_det: got %b want 0", a_det); end
        n_cmp++; if (a_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", a_cnt); end
        n_cmp++; if (a_sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b want 0", a_sat); end
        n_cmp++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", a_err); end
        n_cmp++; if (b_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt_b: got %0d want 0", b_cnt); end
    endtask

    task automatic test_overlap_default();
        logic [6:0] bits = 7'b1011011;
        logic [6:0] exp  = 7'b0001001;
        for (int i = 6; i >= 0; i--) begin
            sequence_valid = 1'b1; sequence_in = bits[i];
            cycle();
            n_cmp++;
            if (a_det !== exp[i]) begin
                n_fail++; $display("FAIL overlap_bit%0d: got %b want %b", 7 - i, a_det, exp[i]);
            end
        end
        idle_inputs();
        n_cmp++; if (a_cnt !== 8'd2) begin n_fail++; $display("FAIL overlap_cnt: got %0d want 2", a_cnt); end
    endtask

    task automatic test_non_overlap();
        logic [6:0] bits = 7'b1011011;
        logic [6:0] exp  = 7'b0001000;
        cfg_load = 1'b1; cfg_pattern = 8'b0000_1011; cfg_len = 4'd4; cfg_overlap = 1'b0; count_clr = 1'b1;
        cycle();
        idle_inputs();
        n_cmp++; if (a_cnt !== 8'd0) begin n_fail++; $display("FAIL nonov_clr: got %0d want 0", a_cnt); end
        n_cmp++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL nonov_err: got %b want 0", a_err); end
        for (int i = 6; i >= 0; i--) begin
            sequence_valid = 1'b1; sequence_in = bits[i];
            cycle();
            n_cmp++;
            if (a_det !== exp[i]) begin
                n_fail++; $display("FAIL nonov_bit%0d: got %b want %b", 7 - i, a_det, exp[i]);
            end
        end
        idle_inputs();
        n_cmp++; if (a_cnt !== 8'd1) begin n_fail++; $display("FAIL nonov_cnt: got %0d want 1", a_cnt); end
    endtask

    task automatic test_gaps();
        // valid bits only: 1,1,1,0,0,0,0,1,1,0,1,1 -> single 1011 ending at k=16
        logic [17:0] bits = 18'b1111_0100_0010_1001_11;
        cfg_load = 1'b1; cfg_pattern = 8'b0000_1011; cfg_len = 4'd4; cfg_overlap = 1'b1; count_clr = 1'b1;
        cycle();
        idle_inputs();
        for (int k = 0; k < 18; k++) begin
            sequence_valid = ((k % 3) != 2);
            sequence_in    = bits[17 - k];
            cycle();
            n_cmp++;
            if (a_det !== (k == 16)) begin
                n_fail++; $display("FAIL gaps_k%0d: got %b want %b", k, a_det, (k == 16));
            end
        end
        idle_inputs();
        n_cmp++; if (a_cnt !== 8'd1) begin n_fail++; $display("FAIL gaps_cnt: got %0d want 1", a_cnt); end
    endtask

    task automatic test_reconfig();
        logic [2:0] pre  = 3'b101;
        logic [2:0] post = 3'b110;
        logic [2:0] exp  = 3'b001;
        for (int i = 2; i >= 0; i--) begin
            sequence_valid = 1'b1; sequence_in = pre[i];
            cycle();
            n_cmp++; if (a_det !== 1'b0) begin n_fail++; $display("FAIL reconf_pre%0d: got %b want 0", 3 - i, a_det); end
        end
        cfg_load = 1'b1; cfg_pattern = 8'b0000_0110; cfg_len = 4'd3; cfg_overlap = 1'b1;
        sequence_valid = 1'b1; sequence_in = 1'b0;
        cycle();
        idle_inputs();
        n_cmp++; if (a_det !== 1'b0) begin n_fail++; $display("FAIL reconf_load_det: got %b want 0", a_det); end
        n_cmp++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL reconf_load_err: got %b want 0", a_err); end
        for (int i = 2; i >= 0; i--) begin
            sequence_valid = 1'b1; sequence_in = post[i];
            cycle();
            n_cmp++;
            if (a_det !== exp[i]) begin
                n_fail++; $display("FAIL reconf_bit%0d: got %b want %b", 3 - i, a_det, exp[i]);
            end
        end
        idle_inputs();
        n_cmp++; if (a_cnt !== 8'd2) begin n_fail++; $display("FAIL reconf_cnt: got %0d want 2", a_cnt); end
    endtask

    task automatic test_illegal();
        logic [4:0] tail     = 5'b11011;
        logic [4:0] tail_exp = 5'b01001;
        cfg_load = 1'b1; cfg_pattern = 8'b0000_1011; cfg_len = 4'd4; cfg_overlap = 1'b1;
        cycle();
        idle_inputs();
        sequence_valid = 1'b1; sequence_in = 1'b1; cycle();
        sequence_valid = 1'b1; sequence_in = 1'b0; cycle();
        // len 0 with a garbage pattern and a presented 0 that must be dropped
        cfg_load = 1'b1; cfg_len = 4'd0; cfg_pattern = 8'hFF; cfg_overlap = 1'b0;
        sequence_valid = 1'b1; sequence_in = 1'b0;
        cycle();
        idle_inputs();
        n_cmp++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL illegal_len0_err: got %b want 1", a_err); end
        n_cmp++; if (a_det !== 1'b0) begin n_fail++; $display("FAIL illegal_len0_det: got %b want 0", a_det); end
        cycle();
        n_cmp++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_pulse: got %b want 0", a_err); end
        cfg_load = 1'b1; cfg_len = 4'd9; cfg_pattern = 8'hFF; cfg_overlap = 1'b0;
        sequence_valid = 1'b1; sequence_in = 1'b0;
        cycle();
        idle_inputs();
        n_cmp++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL illegal_len9_err: got %b want 1", a_err); end
        // history 1,0 survives; then 1,1 completes 1011, then 0,1,1 overlaps
        for (int i = 4; i >= 0; i--) begin
            sequence_valid = 1'b1; sequence_in = tail[i];
            cycle();
            n_cmp++;
            if (a_det !== tail_exp[i]) begin
                n_fail++; $display("FAIL illegal_tail%0d: got %b want %b", 5 - i, a_det, tail_exp[i]);
            end
        end
        idle_inputs();
        n_cmp++; if (a_cnt !== 8'd4) begin n_fail++; $display("FAIL illegal_cnt: got %0d want 4", a_cnt); end
        n_cmp++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_end: got %b want 0", a_err); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic       exp_sat [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        cfg_load = 1'b1; cfg_pattern = 8'b0000_0001; cfg_len = 4'd1; cfg_overlap = 1'b1; count_clr = 1'b1;
        cycle();
        idle_inputs();
        n_cmp++; if (b_cnt !== 2'd0) begin n_fail++; $display("FAIL sat_clr_cnt: got %0d want 0", b_cnt); end
        n_cmp++; if (b_sat !== 1'b0) begin n_fail++; $display("FAIL sat_clr_sat: got %b want 0", b_sat); end
        for (int i = 0; i < 5; i++) begin
            sequence_valid = 1'b1; sequence_in = 1'b1;
            cycle();
            n_cmp++; if (b_det !== 1'b1) begin n_fail++; $display("FAIL sat_det%0d: got %b want 1", i, b_det); end
            n_cmp++;
            if (b_cnt !== exp_cnt[i]) begin
                n_fail++; $display("FAIL sat_cnt%0d: got %0d want %0d", i, b_cnt, exp_cnt[i]);
            end
            n_cmp++;
            if (b_sat !== exp_sat[i]) begin
                n_fail++; $display("FAIL sat_flag%0d: got %b want %b", i, b_sat, exp_sat[i]);
            end
        end
        // clear coinciding with a match
        count_clr = 1'b1; sequence_valid = 1'b1; sequence_in = 1'b1;
        cycle();
        idle_inputs();
        n_cmp++; if (b_det !== 1'b1) begin n_fail++; $display("FAIL satclr_det: got %b want 1", b_det); end
        n_cmp++; if (b_cnt !== 2'd0) begin n_fail++; $display("FAIL satclr_cnt: got %0d want 0", b_cnt); end
        n_cmp++; if (b_sat !== 1'b0) begin n_fail++; $display("FAIL satclr_sat: got %b want 0", b_sat); end
        n_cmp++; if (a_cnt !== 8'd0) begin n_fail++; $display("FAIL satclr_cnt_a: got %0d want 0", a_cnt); end
        cycle();
        n_cmp++; if (b_det !== 1'b0) begin n_fail++; $display("FAIL sat_idle_det: got %b want 0", b_det); end
        n_cmp++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL sat_err: got %b want 0", b_err); end
    endtask

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        reset       = 1'b1;
        cfg_pattern = 8'h00;
        cfg_len     = 4'd0;
        cfg_overlap = 1'b0;
        idle_inputs();
        #1;
        test_reset();
        test_overlap_default();
        test_non_overlap();
        test_gaps();
        test_reconfig();
        test_illegal();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
